// File: rtl/expr_pkg.sv
// Shared types and constants for the streaming expression checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package expr_pkg;

  // Checker states. S_OPND expects an operand (digit or '('), S_NUM is inside
  // a number, S_CLOSE follows a ')', S_ERR is absorbing until clr.
  typedef enum logic [1:0] {
    S_OPND  = 2'd0,
    S_NUM   = 2'd1,
    S_CLOSE = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  // One-hot character class produced by expr_char_class.
  typedef struct packed {
    logic digit;
    logic op;
    logic open;
    logic close;
    logic other;
  } cls_t;

  // ASCII constants.
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_SLASH = 8'h2F;
  localparam logic [7:0] CH_LP    = 8'h28;
  localparam logic [7:0] CH_RP    = 8'h29;

  // Bit positions inside the operator-enable mask.
  localparam int OPB_ADD = 0;
  localparam int OPB_SUB = 1;
  localparam int OPB_MUL = 2;
  localparam int OPB_DIV = 3;

endpackage

// File: rtl/expr_char_class.sv
// Combinational ASCII classifier: DIGIT / OP / OPEN / CLOSE / OTHER, one-hot.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result is valid whenever the input is.
//
// Ports:
//   in      [7:0]  ASCII character
//   op_mask [3:0]  operator enables (bit0 '+', bit1 '-', bit2 '*', bit3 '/')
//   cls            one-hot class; a disabled operator classifies as OTHER
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0] in,
  input  logic [3:0] op_mask,
  output cls_t       cls
);

  logic is_digit;
  logic is_op;
  logic is_open;
  logic is_close;

  always_comb begin
    is_digit = (in >= CH_0) && (in <= CH_9);
    is_op    = ((in == CH_PLUS)  && op_mask[OPB_ADD]) ||
               ((in == CH_MINUS) && op_mask[OPB_SUB]) ||
               ((in == CH_STAR)  && op_mask[OPB_MUL]) ||
               ((in == CH_SLASH) && op_mask[OPB_DIV]);
    is_open  = (in == CH_LP);
    is_close = (in == CH_RP);

    cls.digit = is_digit;
    cls.op    = is_op;
    cls.open  = is_open;
    cls.close = is_close;
    cls.other = !(is_digit || is_op || is_open || is_close);
  end

endmodule

// File: rtl/expr_checker.sv
// Streaming arithmetic-expression syntax checker, one ASCII char per valid cycle.
// Latency: 1 cycle; a char sampled at edge N shows on out/err/depth after edge N.
// Backpressure: none; every cycle with in_valid high consumes a character.
//
// Ports:
//   clk       system clock
//   clr       synchronous active-high reset, wins over in_valid
//   in_valid  qualifies in
//   in [7:0]  ASCII character
//   out       text so far is a complete, well-formed expression
//   err       sticky syntax error
//   depth     current open-parenthesis count (frozen once in error)
module expr_checker
  import expr_pkg::*;
#(
  parameter int         MAX_DEPTH  = 4,
  parameter int         MAX_DIGITS = 8,
  parameter logic [3:0] OP_MASK    = 4'b0101,
  parameter int         DEPTH_W    = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               out,
  output logic               err,
  output logic [DEPTH_W-1:0] depth
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX  = DEPTH_W'(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ZERO = '0;
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(MAX_DIGITS);
  localparam logic [CNT_W-1:0]   CNT_ZERO   = '0;
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

  state_t             st_q,  st_d;
  logic [DEPTH_W-1:0] dep_q, dep_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  cls_t               cls;

  expr_char_class u_class (
    .in      (in),
    .op_mask (OP_MASK),
    .cls     (cls)
  );

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      st_q  <= S_OPND;
      dep_q <= DEPTH_ZERO;
      cnt_q <= CNT_ZERO;
    end else begin
      st_q  <= st_d;
      dep_q <= dep_d;
      cnt_q <= cnt_d;
    end
  end

  // Next-state logic. Overflow checks precede every increment so neither
  // counter can wrap; S_ERR is reached instead.
  always_comb begin
    st_d  = st_q;
    dep_d = dep_q;
    cnt_d = cnt_q;
    if (in_valid) begin
      unique case (st_q)
        S_OPND: begin
          if (cls.digit) begin
            st_d  = S_NUM;
            cnt_d = CNT_ONE;
          end else if (cls.open && (dep_q != DEPTH_MAX)) begin
            dep_d = dep_q + DEPTH_ONE;
          end else begin
            st_d = S_ERR;
          end
        end
        S_NUM: begin
          if (cls.digit) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
            else                  st_d  = S_ERR;
          end else if (cls.op) begin
            st_d  = S_OPND;
            cnt_d = CNT_ZERO;
          end else if (cls.close && (dep_q != DEPTH_ZERO)) begin
            st_d  = S_CLOSE;
            dep_d = dep_q - DEPTH_ONE;
            cnt_d = CNT_ZERO;
          end else begin
            st_d = S_ERR;
          end
        end
        S_CLOSE: begin
          if (cls.op) begin
            st_d = S_OPND;
          end else if (cls.close && (dep_q != DEPTH_ZERO)) begin
            dep_d = dep_q - DEPTH_ONE;
          end else begin
            st_d = S_ERR;
          end
        end
        S_ERR: begin
          st_d = S_ERR;
        end
        default: begin
          st_d = S_ERR;
        end
      endcase
    end
  end

  // Moore output decode from registered state only.
  always_comb begin
    out   = ((st_q == S_NUM) || (st_q == S_CLOSE)) && (dep_q == DEPTH_ZERO);
    err   = (st_q == S_ERR);
    depth = dep_q;
  end

endmodule

// File: tb/tb_expr_checker.sv
// Directed self-checking bench for expr_checker; four parameterisations share
// one stimulus stream and each check looks at the instance it targets.
module tb_expr_checker;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_c = 8'h20;

  logic       out_def, err_def;
  logic [2:0] dep_def;
  logic       out_d2, err_d2;
  logic [1:0] dep_d2;
  logic       out_g3, err_g3;
  logic [2:0] dep_g3;
  logic       out_sub, err_sub;
  logic [2:0] dep_sub;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  expr_checker u_def (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in_c),
    .out(out_def), .err(err_def), .depth(dep_def)
  );

  expr_checker #(.MAX_DEPTH(2)) u_d2 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in_c),
    .out(out_d2), .err(err_d2), .depth(dep_d2)
  );

  expr_checker #(.MAX_DIGITS(3)) u_g3 (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in_c),
    .out(out_g3), .err(err_g3), .depth(dep_g3)
  );

  expr_checker #(.OP_MASK(4'b0111)) u_sub (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in_c),
    .out(out_sub), .err(err_sub), .depth(dep_sub)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle and leave outputs settled 1 time unit after the edge.
  task automatic cycle(input logic v, input logic r, input logic [7:0] c);
    in_valid = v;
    clr      = r;
    in_c     = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
    in_c     = 8'h20;
  endtask

  task automatic send(input logic [7:0] c);
    cycle(1'b1, 1'b0, c);
  endtask

  task automatic do_clr();
    cycle(1'b0, 1'b1, 8'h20);
  endtask

  initial begin
    logic [7:0] seq2 [8];
    logic [2:0] dep2 [8];
    logic [7:0] digs [8];

    // Reset state.
    do_clr();
    check("rst_out", out_def, 0);
    check("rst_err", err_def, 0);
    check("rst_depth", dep_def, 0);

    // 1+2*3: out alternates 1,0,1,0,1.
    send("1"); check("t1_out_1", out_def, 1);
    send("+"); check("t1_out_plus", out_def, 0);
    send("2"); check("t1_out_2", out_def, 1);
    send("*"); check("t1_out_star", out_def, 0);
    send("3"); check("t1_out_3", out_def, 1);
    check("t1_err", err_def, 0);

    // ((12)+4): depth tracking, out only after final ')'.
    do_clr();
    seq2 = '{"(", "(", "1", "2", ")", "+", "4", ")"};
    dep2 = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd0};
    for (int i = 0; i < 8; i++) begin
      send(seq2[i]);
      check($sformatf("t2_depth_%0d", i), dep_def, dep2[i]);
      check($sformatf("t2_out_%0d", i), out_def, (i == 7) ? 1 : 0);
    end
    check("t2_err", err_def, 0);

    // MAX_DEPTH=2: third '(' errors, depth freezes, error sticks, clr recovers.
    do_clr();
    send("("); send("(");
    check("t3_depth2", dep_d2, 2);
    check("t3_err_pre", err_d2, 0);
    send("(");
    check("t3_err", err_d2, 1);
    check("t3_depth_frozen", dep_d2, 2);
    send("1");
    check("t3_err_sticky", err_d2, 1);
    check("t3_out_err", out_d2, 0);
    do_clr();
    check("t3_clr_out", out_d2, 0);
    check("t3_clr_err", err_d2, 0);
    check("t3_clr_depth", dep_d2, 0);

    // MAX_DIGITS=3: three digits fine, fourth errors.
    do_clr();
    send("1"); send("2"); send("3");
    check("t4_out_3dig", out_g3, 1);
    check("t4_err_3dig", err_g3, 0);
    send("4");
    check("t4_err_4dig", err_g3, 1);
    check("t4_out_4dig", out_g3, 0);

    // Default MAX_DIGITS=8: eight digits fine, ninth errors.
    do_clr();
    digs = '{"1", "2", "3", "4", "5", "6", "7", "8"};
    for (int i = 0; i < 8; i++) send(digs[i]);
    check("t4b_out_8dig", out_def, 1);
    send("9");
    check("t4b_err_9dig", err_def, 1);

    // '-' disabled by default, enabled with OP_MASK=0111.
    do_clr();
    send("5"); send("-");
    check("t5_err_def_minus", err_def, 1);
    check("t5_err_sub_minus", err_sub, 0);
    check("t5_out_sub_minus", out_sub, 0);
    send("6");
    check("t5_out_sub", out_sub, 1);
    check("t5_err_sub", err_sub, 0);

    // in_valid low holds everything, even with a bad character present.
    do_clr();
    send("7");
    check("t6_out_7", out_def, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, "x");
      check($sformatf("t6_idle_out_%0d", i), out_def, 1);
      check($sformatf("t6_idle_err_%0d", i), err_def, 0);
    end
    send("+"); check("t6_out_plus", out_def, 0);
    send("8"); check("t6_out_8", out_def, 1);

    // ')' as the first character.
    do_clr();
    send(")");
    check("t7_err_rp", err_def, 1);
    check("t7_out_rp", out_def, 0);

    // '3' with clr on the same edge is discarded; the next '3' is accepted.
    cycle(1'b1, 1'b1, "3");
    check("t8_out_discard", out_def, 0);
    check("t8_err_discard", err_def, 0);
    send("3");
    check("t8_out_after", out_def, 1);

    // Trailing operator / open paren: incomplete, not an error.
    do_clr();
    send("4"); send("*"); send("(");
    check("t9_out_incomplete", out_def, 0);
    check("t9_err_incomplete", err_def, 0);
    check("t9_depth_incomplete", dep_def, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
